// File: rtl/register_file_8x16.sv
// ============================================================================
// register_file_8x16
// ----------------------------------------------------------------------------
// Purpose:
//   An 8-entry x 16-bit register file that sits downstream of the
//   transfer_or_16bit gate. It supplies operands to the ALU through two
//   asynchronous read ports.
//
//   Each entry's next state comes from its own transfer_or_16bit gate:
//     select    = write strobe for that entry
//     new_data  = wdata
//     hold_data = the entry's current value
//   Every entry captures its gate output on every rising clock edge. An entry
//   whose strobe is low therefore recirculates its own value.
//
// Ports:
//   clk      in   1   system clock; all state updates on the rising edge
//   rst      in   1   synchronous, active-high reset; clears entries and count
//   we       in   1   write enable
//   waddr    in   3   write address
//   wdata    in   16  write data (new_data of the transfer gates)
//   raddr_a  in   3   read port A address
//   raddr_b  in   3   read port B address
//   rdata_a  out  16  read port A data (combinational)
//   rdata_b  out  16  read port B data (combinational)
//   wr_count out  8   committed-write counter, saturates at 8'hFF
//
// Configuration:
//   RF_BYPASS_EN - when defined, a read whose address matches an active
//                  write returns wdata in the same cycle (write-through
//                  forwarding, applied to each port independently). When it
//                  is undefined, the read ports always return stored
//                  contents. Storage and wr_count behave the same in both
//                  builds.
// ============================================================================
module register_file_8x16 #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [7:0]        wr_count
);

    // This function is the transfer_or_16bit gate. It passes new_data when
    // select is high and hold_data when select is low. It is built as AND-OR
    // so that it matches the gate-level upstream block.
    function automatic logic [DATA_W-1:0] transfer_or_16bit(
        input logic              select,
        input logic [DATA_W-1:0] new_data,
        input logic [DATA_W-1:0] hold_data
    );
        transfer_or_16bit = ({DATA_W{select}}  & new_data) |
                            ({DATA_W{~select}} & hold_data);
    endfunction

    logic [DATA_W-1:0] q_r [NUM_REGS];
    logic [DATA_W-1:0] d_s [NUM_REGS];
    logic [NUM_REGS-1:0] sel_s;
    logic [7:0]        wr_count_r;

    // Write decode: sel_s is one-hot when we is high and all-zero otherwise.
    always_comb begin
        sel_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_s[i] = we & (waddr == ADDR_W'(i));
        end
    end

    // Next-state computation: the transfer gate of each entry chooses between wdata and the entry's held value.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            d_s[i] = transfer_or_16bit(sel_s[i], wdata, q_r[i]);
        end
    end

    // Entry storage: the reset clear has priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                q_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                q_r[i] <= d_s[i];
            end
        end
    end

    // Committed-write counter: it saturates at 8'hFF and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_r <= 8'h00;
        end else if (we && (wr_count_r != 8'hFF)) begin
            wr_count_r <= wr_count_r + 8'h01;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign wr_count = wr_count_r;

    // Read ports: each is an asynchronous mux over the entries. With
    // forwarding enabled, a matching active write overrides the stored value.
    always_comb begin
        rdata_a = q_r[raddr_a];
        rdata_b = q_r[raddr_b];
`ifdef RF_BYPASS_EN
        if (we && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = q_r[raddr_a];
        end
        if (we && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = q_r[raddr_b];
        end
`endif
    end

endmodule

// File: tb/tb_register_file_8x16.sv
module tb_register_file_8x16;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain array of words plus an integer write count.
    logic [15:0] mdl [8];
    int          mcount;

    register_file_8x16 dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies the rules for one rising edge to the model, then lets the DUT take the edge.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
            mcount = 0;
        end else if (we) begin
            mdl[waddr] = wdata;
            mcount = (mcount >= 255) ? 255 : mcount + 1;
        end
        @(posedge clk);
        #1;
    endtask

    // This is the value a read should return before the edge. It takes the build's forwarding rule into account.
    function automatic logic [15:0] exp_read(input logic [2:0] addr);
`ifdef RF_BYPASS_EN
        if (we && addr == waddr) return wdata;
`endif
        return mdl[addr];
    endfunction

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; wdata = 16'hFFFF; waddr = 3'd4;
        step();
        waddr = 3'd1;
        step();
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            n_checks++;
            if (rdata_a !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rdata_a[%0d]: got %h expected 0000", i, rdata_a);
            end
            n_checks++;
            if (rdata_b !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rdata_b[%0d]: got %h expected 0000", 7 - i, rdata_b);
            end
        end
        n_checks++;
        if (wr_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wr_count: got %h expected 00", wr_count);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
        step();
        waddr = 3'd5; wdata = 16'hABCD;
        step();
        we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd5;
        #1;
        n_checks++;
        if (rdata_a !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_r3: got %h expected 1234", rdata_a);
        end
        n_checks++;
        if (rdata_b !== 16'hABCD) begin
            n_fail++;
            $display("FAIL wr_r5: got %h expected abcd", rdata_b);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 3 && i != 5) begin
                raddr_a = 3'(i);
                #1;
                n_checks++;
                if (rdata_a !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wr_other[%0d]: got %h expected 0000", i, rdata_a);
                end
            end
        end
        n_checks++;
        if (wr_count !== 8'd2) begin
            n_fail++;
            $display("FAIL wr_count_after_2: got %0d expected 2", wr_count);
        end
    endtask

    task automatic test_hold();
        we = 1'b0; waddr = 3'd3; wdata = 16'hDEAD; raddr_a = 3'd3;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (rdata_a !== 16'h1234) begin
                n_fail++;
                $display("FAIL hold_r3 cycle %0d: got %h expected 1234", c, rdata_a);
            end
        end
        n_checks++;
        if (wr_count !== 8'd2) begin
            n_fail++;
            $display("FAIL hold_wr_count: got %0d expected 2", wr_count);
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] before_exp;
`ifdef RF_BYPASS_EN
        before_exp = 16'h00F0;
`else
        before_exp = 16'h0000;
`endif
        we = 1'b1; waddr = 3'd2; wdata = 16'h00F0; raddr_a = 3'd2; raddr_b = 3'd3;
        #1;
        n_checks++;
        if (rdata_a !== before_exp) begin
            n_fail++;
            $display("FAIL same_cycle_before: got %h expected %h", rdata_a, before_exp);
        end
        n_checks++;
        if (rdata_b !== 16'h1234) begin
            n_fail++;
            $display("FAIL same_cycle_other_port: got %h expected 1234", rdata_b);
        end
        step();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 16'h00F0) begin
            n_fail++;
            $display("FAIL same_cycle_after: got %h expected 00f0", rdata_a);
        end
        n_checks++;
        if (wr_count !== 8'd3) begin
            n_fail++;
            $display("FAIL same_cycle_wr_count: got %0d expected 3", wr_count);
        end
    endtask

    task automatic test_saturation();
        we = 1'b1;
        for (int c = 0; c < 300; c++) begin
            waddr = 3'($urandom_range(0, 7));
            wdata = 16'($urandom);
            step();
            n_checks++;
            if (wr_count !== 8'(mcount) || wr_count === 8'h00) begin
                n_fail++;
                $display("FAIL sat_count write %0d: got %0d expected %0d", c, wr_count, mcount);
            end
        end
        we = 1'b0;
        n_checks++;
        if (wr_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_final: got %h expected ff", wr_count);
        end
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(i);
            #1;
            n_checks++;
            if (rdata_a !== mdl[i] || rdata_b !== mdl[i]) begin
                n_fail++;
                $display("FAIL sat_readback[%0d]: got a=%h b=%h expected %h", i, rdata_a, rdata_b, mdl[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; we = 1'b1; waddr = 3'd7; wdata = 16'h5555; raddr_a = 3'd7;
        step();
        rst = 1'b0; we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 16'h0000 || wr_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got r7=%h cnt=%0d expected 0000/0", rdata_a, wr_count);
        end
        we = 1'b1;
        step();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 16'h5555 || wr_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_mid_rewrite: got r7=%h cnt=%0d expected 5555/1", rdata_a, wr_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 31) == 0);
            we      = $urandom_range(0, 1) == 1;
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 16'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
            #1;
            if (!rst) begin
                n_checks++;
                if (rdata_a !== exp_read(raddr_a) || rdata_b !== exp_read(raddr_b)) begin
                    n_fail++;
                    $display("FAIL rand_read cycle %0d: got a=%h b=%h expected a=%h b=%h",
                             c, rdata_a, rdata_b, exp_read(raddr_a), exp_read(raddr_b));
                end
            end
            step();
            n_checks++;
            if (wr_count !== 8'(mcount)) begin
                n_fail++;
                $display("FAIL rand_wr_count cycle %0d: got %0d expected %0d", c, wr_count, mcount);
            end
        end
        rst = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
        raddr_a = 3'd0; raddr_b = 3'd0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mcount = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_hold();
        test_same_cycle();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
